// File: rtl/alu_defs.sv
// Shared opcode constants, FSM encoding and opcode helpers for the ALU arbiter slice.
package alu_defs;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD        = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB        = 4'd1;
  localparam logic [OP_W-1:0] OP_OR         = 4'd2;
  localparam logic [OP_W-1:0] OP_AND        = 4'd3;
  localparam logic [OP_W-1:0] OP_SLT        = 4'd4;
  localparam logic [OP_W-1:0] OP_SLTU       = 4'd5;
  localparam logic [OP_W-1:0] LAST_VALID_OP = OP_SLTU;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op > LAST_VALID_OP;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU: add/sub with signed-overflow flag, or/and, slt/sltu.
module alu_arbiter_alu
  import alu_defs::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [OP_W-1:0]          op,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic [DATA_W-1:0]        out,
  output logic                     ovf
);

  logic signed [DATA_W:0] sum_x;
  logic signed [DATA_W:0] dif_x;

  // Overflow shows up as disagreement between the two top bits of the sign-extended result.
  function automatic logic ext_ovf(input logic signed [DATA_W:0] x);
    return x[DATA_W] ^ x[DATA_W-1];
  endfunction

  assign sum_x = {a[DATA_W-1], a} + {b[DATA_W-1], b};
  assign dif_x = {a[DATA_W-1], a} - {b[DATA_W-1], b};

  always_comb begin
    out = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin
        out = sum_x[DATA_W-1:0];
        ovf = ext_ovf(sum_x);
      end
      OP_SUB: begin
        out = dif_x[DATA_W-1:0];
        ovf = ext_ovf(dif_x);
      end
      OP_OR:   out = a | b;
      OP_AND:  out = a & b;
      OP_SLT:  out = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_SLTU: out = {{(DATA_W-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
      default: begin
        out = '0;
        ovf = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a single shared ALU: IDLE accepts, EXEC computes,
// RESP holds the result until the granted requester consumes it.
module alu_arbiter
  import alu_defs::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_ovf,
  output logic              rsp_err
);

  state_e state, nstate;
  logic   last_gnt;
  logic   cur_gnt;
  logic   gnt_sel;
  logic   accept;
  logic   rsp_hs;

  logic [OP_W-1:0]          op_p0;
  logic signed [DATA_W-1:0] a_p0;
  logic signed [DATA_W-1:0] b_p0;

  logic [DATA_W-1:0] alu_out;
  logic              alu_ovf;

  logic [DATA_W-1:0] data_p1;
  logic              ovf_p1;
  logic              err_p1;

  // On a tie the requester that was not served last wins; otherwise whoever is valid.
  assign gnt_sel = (req0_valid & req1_valid) ? ~last_gnt : req1_valid;
  assign accept  = (state == ST_IDLE) & (req0_valid | req1_valid) & ~reset;
  assign rsp_hs  = (state == ST_RESP) & (cur_gnt ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      last_gnt <= 1'b1;
      cur_gnt  <= 1'b0;
    end else begin
      state <= nstate;
      if (accept) cur_gnt <= gnt_sel;
      if (rsp_hs) last_gnt <= cur_gnt;
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE: if (accept) nstate = ST_EXEC;
      ST_EXEC: nstate = ST_RESP;
      ST_RESP: if (rsp_hs) nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = accept & ~gnt_sel;
    req1_ready = accept & gnt_sel;
    rsp0_valid = (state == ST_RESP) & ~cur_gnt & ~reset;
    rsp1_valid = (state == ST_RESP) & cur_gnt & ~reset;
  end

  // Stage p0: operand capture on the accept handshake only.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= gnt_sel ? req1_op : req0_op;
      a_p0  <= gnt_sel ? req1_a  : req0_a;
      b_p0  <= gnt_sel ? req1_b  : req0_b;
    end
  end

  alu_arbiter_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op (op_p0),
    .a  (a_p0),
    .b  (b_p0),
    .out(alu_out),
    .ovf(alu_ovf)
  );

  // Stage p1: result registers, written once in EXEC and held through RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p1 <= '0;
      ovf_p1  <= 1'b0;
      err_p1  <= 1'b0;
    end else if (state == ST_EXEC) begin
      err_p1  <= op_illegal(op_p0);
      data_p1 <= op_illegal(op_p0) ? '0 : alu_out;
      ovf_p1  <= op_illegal(op_p0) ? 1'b0 : alu_ovf;
    end
  end

  assign rsp_data = data_p1;
  assign rsp_ovf  = ovf_p1;
  assign rsp_err  = err_p1;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-004 SHALL have ports: reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-005 SHALL have ports: reqN_op  input  4  ALU opcode (0 add, 1 sub, 2 or, 3 and, 4 slt, 5 sltu).
REQ-006 SHALL have ports: reqN_a, reqN_b  input  32  operands num1, num2.
REQ-007 SHALL have ports: rspN_valid  output  1  result for requester N available.
REQ-008 SHALL have ports: rspN_ready  input  1  requester N consumes the result.
REQ-009 SHALL have ports: rsp_data  output  32 and rsp_ovf  output  1, shared by both response channels.
REQ-010 SHALL have port: rsp_err  output  1  accepted opcode was outside 0..5.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-012 In IDLE, SHALL grant one valid requester; when both are valid, SHALL grant the requester not granted last (round-robin).
REQ-013 SHALL drive reqN_ready=1 combinationally only in IDLE for the granted requester; all other readys 0.
REQ-014 On valid&ready, SHALL capture op/a/b into internal registers and move to EXEC.
REQ-015 Requesters SHALL hold valid/op/a/b stable until ready; the arbiter SHALL NOT sample them outside the accept cycle.
REQ-016 In EXEC (one cycle), SHALL latch ALU out/overflow from captured operands into result registers and move to RESP.
REQ-017 For op 6..15, SHALL latch rsp_data=0, rsp_ovf=0, rsp_err=1; for op 0..5, rsp_err=0.
REQ-018 rsp_ovf SHALL be 1 only for signed overflow of add/sub (33-bit sign-extended compare); 0 for all other ops.
REQ-019 In RESP, SHALL assert rspN_valid for the granted requester only, hold rsp_data/rsp_ovf/rsp_err stable, and wait indefinitely for rspN_ready.
REQ-020 On rspN_valid&rspN_ready, SHALL update last-grant to N and return to IDLE; the next accept is possible one cycle later.
REQ-021 Latency: accept in cycle T -> rspN_valid first high in cycle T+2; max throughput one op per 3 cycles.
REQ-022 rspN_ready while rspN_valid=0 SHALL be ignored; reqN_valid while not in IDLE SHALL be ignored (ready stays 0).
REQ-023 Arithmetic SHALL be 32-bit wrap-around (add 0xFFFFFFFF+1 -> 0).

Reset
REQ-024 On reset=1 at a clock edge, SHALL go to IDLE with last-grant=1 (requester 0 wins first tie), result registers 0, rsp_err 0.
REQ-025 During and after reset, all reqN_ready and rspN_valid SHALL be 0 until the next IDLE evaluation; rsp_data=0, rsp_ovf=0.
REQ-026 Reset mid-operation (EXEC or RESP) SHALL discard the transaction; no response is produced for it.

Structure
REQ-027 Opcode constants (ADD..SLTU, LAST_VALID_OP=5) and FSM state encodings SHALL live in the shared alu_defs package/header.
REQ-028 SHALL instantiate exactly one existing ALU sub-module, fed from the captured op/operand registers; no second adder.
REQ-029 Arbitration, FSM and result registers SHALL reside in alu_arbiter; expected size 120-250 lines.

Verification
REQ-030 Single op: req0 add 0x7FFFFFFF+0x00000001 -> accept T, rsp0_valid at T+2, rsp_data=0x80000000, rsp_ovf=1, rsp_err=0.
REQ-031 Contention: both valid from reset (req0 sub 5-7, req1 sltu 1<0xFFFFFFFF) -> req0 first (0xFFFFFFFE, ovf 0), then req1 (data 1); next tie grants req0 again.
REQ-032 Back-pressure: rsp1_ready held 0 for 10 cycles -> rsp1_valid and rsp_data stable all 10 cycles, no new ready asserted; released on ready.
REQ-033 Illegal op: req0 op=9 -> rsp_data=0, rsp_ovf=0, rsp_err=1 at T+2.
REQ-034 Reset mid-RESP: assert reset while rsp0_valid=1 -> next cycle rsp0_valid=0, state IDLE, rsp_data=0; pending req1 then granted first only if req0 idle.
REQ-035 Signed/unsigned: slt 0xFFFFFFFF<1 -> 1; sltu 0xFFFFFFFF<1 -> 0; both rsp_ovf=0.
